mmu_seg: RTL and testbench

- Multi-segment base/bound address translator for shader memory requests; sits between a core's load/store unit and the memory arbiter.
- NUM_SEGS independently programmable segments, each with base, bound and enable; selected by the top bits of the virtual address.
- One-stage registered translation pipeline with valid/ready handshake, per-request fault code, and a saturating fault counter.

---
 rtl/mmu_seg.sv | 113 +++++++++++
 tb/tb_mmu_seg.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_seg.sv
// Segmented base/bound address translator with a one-stage registered valid/ready pipeline and fault counter.
// Define MMU_PERM_EN to add per-segment store permission (i_write, i_cfg_wr_ok).
module mmu_seg #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SEGS   = 4,
  parameter int SEG_W      = $clog2(NUM_SEGS),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cfg_we,
  input  logic [SEG_W-1:0]      i_cfg_seg,
  input  logic [ADDR_WIDTH-1:0] i_cfg_base,
  input  logic [ADDR_WIDTH-1:0] i_cfg_bound,
  input  logic                  i_cfg_en,
`ifdef MMU_PERM_EN
  input  logic                  i_cfg_wr_ok,
  input  logic                  i_write,
`endif
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_virtual_addr,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] o_physical_addr,
  output logic                  o_error,
  output logic [1:0]            o_err_code,
  output logic [CNT_WIDTH-1:0]  o_fault_count,
  input  logic                  i_fault_clr
);

  localparam int OFF_W = ADDR_WIDTH - SEG_W;

  logic [ADDR_WIDTH-1:0] seg_base  [NUM_SEGS];
  logic [ADDR_WIDTH-1:0] seg_bound [NUM_SEGS];
  logic [NUM_SEGS-1:0]   seg_en;
`ifdef MMU_PERM_EN
  logic [NUM_SEGS-1:0]   seg_wr_ok;
`endif

  logic [SEG_W-1:0]      req_seg;
  logic [ADDR_WIDTH-1:0] req_off;
  logic [ADDR_WIDTH:0]   req_sum;
  logic [1:0]            req_code;
  logic                  accept;
  logic                  done;

  assign req_seg = i_virtual_addr[ADDR_WIDTH-1 -: SEG_W];
  assign req_off = {{SEG_W{1'b0}}, i_virtual_addr[OFF_W-1:0]};
  assign req_sum = {1'b0, seg_base[req_seg]} + {1'b0, req_off};

  // Check order gives disabled > bound > overflow/permission.
  always_comb begin
    req_code = 2'd0;
    if (!seg_en[req_seg])
      req_code = 2'd1;
    else if (req_off >= seg_bound[req_seg])
      req_code = 2'd2;
    else if (req_sum[ADDR_WIDTH])
      req_code = 2'd3;
`ifdef MMU_PERM_EN
    else if (i_write && !seg_wr_ok[req_seg])
      req_code = 2'd3;
`endif
  end

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  assign done    = o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SEGS; s++) begin
        seg_base[s]  <= '0;
        seg_bound[s] <= '0;
      end
      seg_en          <= '0;
`ifdef MMU_PERM_EN
      seg_wr_ok       <= '0;
`endif
      o_valid         <= 1'b0;
      o_physical_addr <= '0;
      o_error         <= 1'b0;
      o_err_code      <= 2'd0;
      o_fault_count   <= '0;
    end else begin
      // Table write lands at this edge; a same-cycle request already saw the old entry.
      if (i_cfg_we) begin
        seg_base[i_cfg_seg]  <= i_cfg_base;
        seg_bound[i_cfg_seg] <= i_cfg_bound;
        seg_en[i_cfg_seg]    <= i_cfg_en;
`ifdef MMU_PERM_EN
        seg_wr_ok[i_cfg_seg] <= i_cfg_wr_ok;
`endif
      end

      if (accept) begin
        o_valid         <= 1'b1;
        o_physical_addr <= req_sum[ADDR_WIDTH-1:0];
        o_error         <= (req_code != 2'd0);
        o_err_code      <= req_code;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end

      if (i_fault_clr)
        o_fault_count <= '0;
      else if (done && o_error && !(&o_fault_count))
        o_fault_count <= o_fault_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mmu_seg.sv
// Randomized plus directed bench for mmu_seg against a queue-based reference model.
module tb_mmu_seg;
  localparam int AW = 32;
  localparam int NS = 4;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic [31:0] pa;
    logic        err;
    logic [1:0]  code;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cfg_we;
  logic [1:0]    i_cfg_seg;
  logic [AW-1:0] i_cfg_base;
  logic [AW-1:0] i_cfg_bound;
  logic          i_cfg_en;
`ifdef MMU_PERM_EN
  logic          i_cfg_wr_ok;
  logic          i_write;
`endif
  logic          i_valid;
  logic          o_ready;
  logic [AW-1:0] i_virtual_addr;
  logic          o_valid;
  logic          i_ready;
  logic [AW-1:0] o_physical_addr;
  logic          o_error;
  logic [1:0]    o_err_code;
  logic [CW-1:0] o_fault_count;
  logic          i_fault_clr;

  always #5 clk = ~clk;

  mmu_seg #(.ADDR_WIDTH(AW), .NUM_SEGS(NS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_we(i_cfg_we), .i_cfg_seg(i_cfg_seg), .i_cfg_base(i_cfg_base),
    .i_cfg_bound(i_cfg_bound), .i_cfg_en(i_cfg_en),
`ifdef MMU_PERM_EN
    .i_cfg_wr_ok(i_cfg_wr_ok), .i_write(i_write),
`endif
    .i_valid(i_valid), .o_ready(o_ready), .i_virtual_addr(i_virtual_addr),
    .o_valid(o_valid), .i_ready(i_ready), .o_physical_addr(o_physical_addr),
    .o_error(o_error), .o_err_code(o_err_code), .o_fault_count(o_fault_count),
    .i_fault_clr(i_fault_clr)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_done = 0;
  bit last_acc;

  // Reference model state
  longint unsigned m_base  [NS];
  longint unsigned m_bound [NS];
  bit              m_en    [NS];
`ifdef MMU_PERM_EN
  bit              m_wok   [NS];
`endif
  int              m_cnt;
  rsp_t            q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic rsp_t xlate(input logic [31:0] va);
    rsp_t r;
    int s;
    longint unsigned off, sum;
    s   = int'(va >> 30);
    off = longint'(va) % (64'd1 << 30);
    sum = m_base[s] + off;
    r.pa = sum[31:0];
    if (!m_en[s])                    r.code = 2'd1;
    else if (off >= m_bound[s])      r.code = 2'd2;
    else if (sum >= (64'd1 << 32))   r.code = 2'd3;
`ifdef MMU_PERM_EN
    else if (i_write && !m_wok[s])   r.code = 2'd3;
`endif
    else                             r.code = 2'd0;
    r.err = (r.code != 2'd0);
    return r;
  endfunction

  // Inputs are already driven at the falling edge; compare, advance model, then clock once.
  task automatic tick();
    rsp_t r;
    bit acc, dn;
    #1;
    chk("o_ready", o_ready, (q.size() == 0 || i_ready));
    chk("o_valid", o_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("pa", o_physical_addr, q[0].pa);
      chk("error", o_error, q[0].err);
      chk("err_code", o_err_code, q[0].code);
    end
    chk("fault_count", o_fault_count, m_cnt);
    acc = i_valid && (q.size() == 0 || i_ready);
    dn  = (q.size() != 0) && i_ready;
    if (acc) r = xlate(i_virtual_addr);
    if (dn) begin
      if (q[0].err && m_cnt < CNT_MAX) m_cnt++;
      void'(q.pop_front());
      n_done++;
    end
    if (i_fault_clr) m_cnt = 0;
    if (acc) q.push_back(r);
    if (i_cfg_we) begin
      m_base[i_cfg_seg]  = i_cfg_base;
      m_bound[i_cfg_seg] = i_cfg_bound;
      m_en[i_cfg_seg]    = i_cfg_en;
`ifdef MMU_PERM_EN
      m_wok[i_cfg_seg]   = i_cfg_wr_ok;
`endif
    end
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] s, input logic [31:0] b, input logic [31:0] bd, input logic en);
    i_cfg_we = 1'b1; i_cfg_seg = s; i_cfg_base = b; i_cfg_bound = bd; i_cfg_en = en;
    tick();
    i_cfg_we = 1'b0;
  endtask

  task automatic req(input logic [31:0] va);
    i_valid = 1'b1; i_ready = 1'b1; i_virtual_addr = va;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] stream [4];
    logic [1:0]  seg;
    logic [31:0] off;
    int idx, d0;

    rst_n = 1'b0; i_cfg_we = 1'b0; i_cfg_seg = '0; i_cfg_base = '0; i_cfg_bound = '0;
    i_cfg_en = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_virtual_addr = '0; i_fault_clr = 1'b0;
`ifdef MMU_PERM_EN
    i_cfg_wr_ok = 1'b1; i_write = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_pa", o_physical_addr, 0);
    chk("rst_error", o_error, 0);
    chk("rst_code", o_err_code, 0);
    chk("rst_count", o_fault_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < NS; s++) begin
      m_base[s] = 0; m_bound[s] = 0; m_en[s] = 0;
`ifdef MMU_PERM_EN
      m_wok[s] = 0;
`endif
    end
    m_cnt = 0;

    // Reset leaves every segment disabled
    req(32'h4000_0010);
    chk("rst_seg_disabled", o_err_code, 1);
    i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0;

    cfg(2'd1, 32'h1000_0000, 32'h100, 1'b1);
    req(32'h4000_0010);
    chk("tp_pa", o_physical_addr, 32'h1000_0010);
    chk("tp_ok", {o_valid, o_error, o_err_code}, 4'b1000);
    req(32'h4000_00FF);
    chk("tp_last_in_bound", {o_physical_addr, o_error}, {32'h1000_00FF, 1'b0});
    req(32'h4000_0100);
    chk("tp_bound_code", o_err_code, 2);
    tick();
    chk("tp_count1", o_fault_count, 1);
    req(32'h8000_0000);
    chk("tp_disabled", o_err_code, 1);
    cfg(2'd3, 32'hFFFF_FF00, 32'h3FFF_FFFF, 1'b1);
    req(32'hC000_0200);
    chk("tp_overflow", o_err_code, 3);
    tick();

    // Stalled consumer with a four-request stream
    for (int k = 0; k < 4; k++) stream[k] = 32'h4000_0000 + 32'(k);
    idx = 0; d0 = n_done;
    for (int c = 0; c < 40 && (idx < 4 || q.size() != 0); c++) begin
      i_ready = (c >= 3);
      i_valid = (idx < 4);
      i_virtual_addr = stream[idx % 4];
      tick();
      if (last_acc) idx++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    chk("stall_accepted", idx, 4);
    chk("stall_delivered", n_done - d0, 4);

    // Same-cycle table write does not affect the request beside it
    i_cfg_we = 1'b1; i_cfg_seg = 2'd1; i_cfg_base = 32'h1000_0000; i_cfg_bound = 32'h0; i_cfg_en = 1'b1;
    req(32'h4000_0010);
    i_cfg_we = 1'b0;
    chk("samecyc_old", o_error, 0);
    req(32'h4000_0010);
    chk("samecyc_new", o_err_code, 2);
    tick();

    for (int k = 0; k < 20; k++) req(32'h8000_0004);
    tick();
    chk("sat_count", o_fault_count, CNT_MAX);
    req(32'h8000_0004);
    i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0;
    chk("clr_priority", o_fault_count, 0);

`ifdef MMU_PERM_EN
    i_cfg_wr_ok = 1'b0;
    cfg(2'd1, 32'h1000_0000, 32'h100, 1'b1);
    i_write = 1'b1;
    req(32'h4000_0010);
    i_write = 1'b0;
    chk("perm_store", o_err_code, 3);
    tick();
`endif

    for (int c = 0; c < 800; c++) begin
      i_cfg_we    = ($urandom_range(0, 7) == 0);
      i_cfg_seg   = 2'($urandom_range(0, 3));
      i_cfg_base  = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFFF - $urandom_range(0, 255));
      i_cfg_bound = $urandom_range(0, 1) ? $urandom_range(0, 64) : $urandom;
      i_cfg_en    = ($urandom_range(0, 3) != 0);
`ifdef MMU_PERM_EN
      i_cfg_wr_ok = $urandom_range(0, 1);
      i_write     = $urandom_range(0, 1);
`endif
      i_valid     = $urandom_range(0, 1);
      i_ready     = ($urandom_range(0, 3) != 0);
      i_fault_clr = ($urandom_range(0, 31) == 0);
      seg = 2'($urandom_range(0, 3));
      off = $urandom_range(0, 1) ? $urandom_range(0, 80) : $urandom;
      i_virtual_addr = {seg, off[29:0]};
      tick();
    end
    i_cfg_we = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_fault_clr = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
